// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Hazard detection and stall control for the 5-stage MIPS pipeline. It sits
//   beside ID and compares the ID-stage source registers against the EX and MEM
//   destinations. When a load in EX feeds a branch that is compared in ID, the
//   unit stalls for LB_STALLS cycles. Cycles after the first are held by a
//   registered down-counter rather than detected again.
//
// Parameters
//   LB_STALLS     stall cycles for a load in EX feeding a branch in ID (1..3)
//   CNT_W         width of stall_count
//
// Ports
//   clk, reset    rising-edge clock; synchronous active-high reset
//   id_rs/id_rt   source register fields of the ID instruction
//   id_uses_rs/rt ID instruction reads that source
//   id_is_branch  ID instruction is beq/bne
//   branch_taken  ID-stage branch resolved taken
//   ex_mem_read   EX instruction is a load
//   ex_reg_write  EX instruction writes a register
//   ex_rd         EX destination register
//   mem_mem_read  MEM instruction is a load
//   mem_rd        MEM destination register
//   pc_write      PC may update
//   ifid_write    IF/ID may load
//   idex_bubble   ID/EX loads a NOP
//   ifid_flush    IF/ID loads a NOP (taken branch)
//   stall_count   stalled cycles since reset, saturating
module hazard_stall_unit #(
  parameter int unsigned LB_STALLS = 2,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             branch_taken,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_rd,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_rd,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  localparam logic [1:0] REM_INIT = 2'(LB_STALLS - 1);

  state_e           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q;

  logic match_ex, match_mem;
  logic lu, ba, bm, lb;
  logic stall;

  function automatic logic src_match(input logic [4:0] r, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic use_rs,
                                     input logic use_rt);
    return (r != 5'd0) && ((use_rs && rs == r) || (use_rt && rt == r));
  endfunction

  always_comb begin
    match_ex  = src_match(ex_rd, id_rs, id_rt, id_uses_rs, id_uses_rt);
    match_mem = src_match(mem_rd, id_rs, id_rt, id_uses_rs, id_uses_rt);
    lu = ex_mem_read && match_ex;
    ba = id_is_branch && ex_reg_write && !ex_mem_read && match_ex;
    bm = id_is_branch && mem_mem_read && match_mem;
    lb = lu && id_is_branch;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall = lu || ba || bm;
        if (lb && (LB_STALLS > 1)) begin
          state_d = HOLD;
          rem_d   = REM_INIT;
        end
      end
      HOLD: begin
        stall = 1'b1;
        if (rem_q == 2'd1) begin
          state_d = IDLE;
          rem_d   = 2'd0;
        end else begin
          rem_d = rem_q - 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = 2'd0;
      end
    endcase
    // Reset overrides everything, including a stall in progress, so the
    // pipeline sees free-running control while reset is held.
    if (reset) begin
      stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (stall && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    pc_write    = !stall;
    ifid_write  = !stall;
    idex_bubble = stall;
    // A stalled branch has not really resolved yet, so its flush waits.
    ifid_flush  = !reset && branch_taken && !stall;
    stall_count = cnt_q;
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  localparam int LBS = 2;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs, id_rt, ex_rd, mem_rd;
  logic          id_uses_rs, id_uses_rt, id_is_branch, branch_taken;
  logic          ex_mem_read, ex_reg_write, mem_mem_read;
  logic          pc_write, ifid_write, idex_bubble, ifid_flush;
  logic [CW-1:0] stall_count;

  hazard_stall_unit #(.LB_STALLS(LBS), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .branch_taken(branch_taken),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: number of forced stall cycles still owed, and a count.
  int m_pend = 0;
  int m_cnt  = 0;

  // Observed / expected values for the cycle just completed by tick().
  logic [3:0] obs_o, exp_o;    // {pc_write, ifid_write, idex_bubble, ifid_flush}
  int         obs_cnt, exp_cnt;

  function automatic bit uses(input logic [4:0] r);
    return (r != 0) && ((id_uses_rs && id_rs == r) || (id_uses_rt && id_rt == r));
  endfunction

  task automatic clear_inputs();
    reset = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_is_branch = 0; branch_taken = 0; ex_mem_read = 0; ex_reg_write = 0;
    ex_rd = 0; mem_mem_read = 0; mem_rd = 0;
  endtask

  // Called at a negedge with inputs driven; returns at the next negedge.
  task automatic tick();
    bit lu, ba, bm, st;
    #1;
    lu = ex_mem_read && uses(ex_rd);
    ba = id_is_branch && ex_reg_write && !ex_mem_read && uses(ex_rd);
    bm = id_is_branch && mem_mem_read && uses(mem_rd);
    if (reset)           st = 0;
    else if (m_pend > 0) st = 1;
    else                 st = lu || ba || bm;
    exp_o = {!st, !st, st, (!reset && branch_taken && !st)};
    obs_o = {pc_write, ifid_write, idex_bubble, ifid_flush};
    @(posedge clk);
    if (reset) begin
      m_pend = 0; m_cnt = 0;
    end else begin
      if (st && m_cnt < CMAX) m_cnt++;
      if (m_pend > 0) m_pend--;
      else if (lu && id_is_branch) m_pend = LBS - 1;
    end
    #1;
    obs_cnt = int'(stall_count);
    exp_cnt = m_cnt;
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1; ex_mem_read = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (obs_o !== 4'b1100) begin
        fails++;
        $display("FAIL reset_outputs cyc%0d: got %b want 1100", i, obs_o);
      end
    end
    clear_inputs();
    tick();
    tests++;
    if (obs_cnt !== 0) begin
      fails++;
      $display("FAIL reset_count: got %0d want 0", obs_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 1;
    tick();
    tests++;
    if (obs_o !== 4'b0010 || obs_cnt !== 1) begin
      fails++;
      $display("FAIL load_use: got o=%b cnt=%0d want o=0010 cnt=1", obs_o, obs_cnt);
    end
    clear_inputs();
    tick();
    tests++;
    if (obs_o !== 4'b1100 || obs_cnt !== 1) begin
      fails++;
      $display("FAIL load_use_after: got o=%b cnt=%0d want o=1100 cnt=1", obs_o, obs_cnt);
    end
  endtask

  task automatic test_load_branch();
    logic [3:0] want [3] = '{4'b0010, 4'b0010, 4'b1100};
    int         wcnt [3] = '{1, 2, 2};
    do_reset();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 9; id_rt = 9; id_uses_rt = 1; id_is_branch = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      clear_inputs();
      tests++;
      if (obs_o !== want[i] || obs_cnt !== wcnt[i]) begin
        fails++;
        $display("FAIL load_branch cyc%0d: got o=%b cnt=%0d want o=%b cnt=%0d",
                 i, obs_o, obs_cnt, want[i], wcnt[i]);
      end
    end
  endtask

  task automatic test_no_hazard();
    do_reset();
    ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_uses_rs = 1;
    tick();
    tests++;
    if (obs_o !== 4'b1100) begin
      fails++;
      $display("FAIL zero_reg: got %b want 1100", obs_o);
    end
    ex_rd = 8; id_rs = 8; id_uses_rs = 0;
    tick();
    tests++;
    if (obs_o !== 4'b1100 || obs_cnt !== 0) begin
      fails++;
      $display("FAIL unused_rs: got o=%b cnt=%0d want o=1100 cnt=0", obs_o, obs_cnt);
    end
  endtask

  task automatic test_flush();
    do_reset();
    id_is_branch = 1; branch_taken = 1; ex_reg_write = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1;
    tick();
    tests++;
    if (obs_o !== 4'b0010) begin
      fails++;
      $display("FAIL flush_suppressed: got %b want 0010", obs_o);
    end
    ex_reg_write = 0;
    tick();
    tests++;
    if (obs_o !== 4'b1101) begin
      fails++;
      $display("FAIL flush_taken: got %b want 1101", obs_o);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    ex_mem_read = 1; ex_rd = 9; id_rt = 9; id_uses_rt = 1; id_is_branch = 1;
    tick();
    clear_inputs();
    reset = 1;
    tick();
    tests++;
    if (obs_o !== 4'b1100) begin
      fails++;
      $display("FAIL reset_hold_outputs: got %b want 1100", obs_o);
    end
    reset = 0;
    tick();
    tests++;
    if (obs_o !== 4'b1100 || obs_cnt !== 0) begin
      fails++;
      $display("FAIL reset_hold_after: got o=%b cnt=%0d want o=1100 cnt=0", obs_o, obs_cnt);
    end
  endtask

  task automatic test_lu_and_bm();
    do_reset();
    id_is_branch = 1; id_uses_rs = 1; id_uses_rt = 1; id_rs = 3; id_rt = 4;
    mem_mem_read = 1; mem_rd = 4; ex_mem_read = 1; ex_rd = 3;
    tick();
    tests++;
    if (obs_o !== 4'b0010 || obs_cnt !== 1) begin
      fails++;
      $display("FAIL lu_bm: got o=%b cnt=%0d want o=0010 cnt=1", obs_o, obs_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    ex_mem_read = 1; ex_rd = 7; id_rs = 7; id_uses_rs = 1;
    for (int i = 0; i < CMAX + 4; i++) tick();
    tests++;
    if (obs_cnt !== CMAX || obs_o !== 4'b0010) begin
      fails++;
      $display("FAIL saturation: got cnt=%0d o=%b want cnt=%0d o=0010", obs_cnt, obs_o, CMAX);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 39) == 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      mem_rd       = 5'($urandom_range(0, 3));
      id_uses_rs   = 1'($urandom);
      id_uses_rt   = 1'($urandom);
      id_is_branch = 1'($urandom);
      branch_taken = 1'($urandom);
      ex_mem_read  = 1'($urandom);
      ex_reg_write = 1'($urandom);
      mem_mem_read = 1'($urandom);
      tick();
      tests++;
      if (obs_o !== exp_o || obs_cnt !== exp_cnt) begin
        fails++;
        $display("FAIL random cyc%0d: got o=%b cnt=%0d want o=%b cnt=%0d",
                 i, obs_o, obs_cnt, exp_o, exp_cnt);
      end
    end
  endtask

  initial begin
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_load_branch();
    test_no_hazard();
    test_flush();
    test_reset_mid_hold();
    test_lu_and_bm();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
